// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: record/playback sequencer and single-port
// arbiter for the PDM audio capture RAM.
//
// Ports:
//   clk, reset         clock; sync active-low reset
//   rec_req, play_req  one-cycle start pulses
//   stop_req           one-cycle abort pulse
//   loop_en            playback wraps to sample 0 at end
//   sample_valid/in    decimated sample strobe + data
//   ram_addr/we/wdata  registered RAM port controls
//   ram_rdata          RAM data, 1 cycle after ram_addr
//   audio_out/valid    playback sample + update pulse
//   stored_len         samples held in RAM, 0..DEPTH
//   busy               active, or reads still in flight
//   led                progress thermometer
module rec_play_ctrl #(
  parameter int unsigned DEPTH = 131072,
  parameter int unsigned DW = 8,
  parameter logic [DW-1:0] IDLE_LEVEL = 'h80,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rec_req,
  input  logic          play_req,
  input  logic          stop_req,
  input  logic          loop_en,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] audio_out,
  output logic          audio_valid,
  output logic [AW:0]   stored_len,
  output logic          busy,
  output logic [3:0]    led
);

  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t state, state_d;

  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW-1:0] rd_ptr, rd_ptr_d;
  logic [AW:0]   len_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          we_d;
  logic          rd_issue;
  logic          rd_p1;
  logic          rd_p2;
  logic          rd_last;
  logic [1:0]    wr_msb;
  logic [1:0]    rd_msb;

  // rd_p1: address on the bus; rd_p2: ram_rdata valid.
  assign busy = (state != IDLE) | rd_p1 | rd_p2;

  assign rd_last =
    ({1'b0, rd_ptr} == stored_len - LW'(1));

  assign wr_msb = wr_ptr[AW-1 -: 2];
  assign rd_msb = rd_ptr[AW-1 -: 2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    len_d    = stored_len;
    addr_d   = ram_addr;
    wdata_d  = ram_wdata;
    we_d     = 1'b0;
    rd_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stop_req && !busy) begin
          if (rec_req) begin
            state_d  = REC;
            wr_ptr_d = '0;
            len_d    = '0;
          end else if (play_req &&
                       stored_len != '0) begin
            state_d  = PLAY;
            rd_ptr_d = '0;
          end
        end
      end
      REC: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          we_d     = 1'b1;
          addr_d   = wr_ptr;
          wdata_d  = sample_in;
          wr_ptr_d = wr_ptr + AW'(1);
          // Counting per write makes a stop
          // land on the exact issued count.
          len_d    = stored_len + LW'(1);
          if (wr_ptr == LAST) begin
            state_d = IDLE;
          end
        end
      end
      PLAY: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          rd_issue = 1'b1;
          addr_d   = rd_ptr;
          if (rd_last) begin
            rd_ptr_d = '0;
            if (!loop_en) begin
              state_d = IDLE;
            end
          end else begin
            rd_ptr_d = rd_ptr + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      stored_len  <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      audio_out   <= IDLE_LEVEL;
      audio_valid <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      stored_len  <= len_d;
      ram_addr    <= addr_d;
      ram_we      <= we_d;
      ram_wdata   <= wdata_d;
      rd_p1       <= rd_issue;
      rd_p2       <= rd_p1;
      audio_valid <= rd_p2;
      if (rd_p2) begin
        audio_out <= ram_rdata;
      end
    end
  end

  // REC fills upward from bit 0; PLAY drains
  // downward from bit 3 as the read advances.
  always_comb begin
    led = 4'b0000;
    unique case (1'b1)
      (state == REC):
        led = 4'b1111 >> (2'd3 - wr_msb);
      (state == PLAY):
        led = 4'b1111 << rd_msb;
      default:
        led = 4'b0000;
    endcase
  end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Sequencer and single-port arbiter for the audio capture RAM in the PDM record/playback path.
- Accepts decimated samples (sample_valid strobe) from the sinc3 stage.
- On request, records samples into the external single-port RAM, remembers the recorded length, and plays them back at the same strobe rate.
- Drives the RAM address/write-enable from whichever activity owns the port, plus the progress LEDs and the audio output.

Parameters:
- DEPTH, 131072, RAM depth in samples; must be a power of 2, minimum 4. Localparam AW = $clog2(DEPTH).
- DW, 8, sample width in bits.
- IDLE_LEVEL, 8'h80, audio_out value after reset (mid-scale).

Ports:
- clk  in  1  system clock (44 MHz)
- reset  in  1  synchronous, active-low reset (0 = reset)
- rec_req  in  1  one-cycle pulse, already synchronised and edge-detected: start recording
- play_req  in  1  one-cycle pulse: start playback
- stop_req  in  1  one-cycle pulse: abort current activity
- loop_en  in  1  level: playback wraps to sample 0 instead of ending
- sample_valid  in  1  one-cycle strobe, one per decimated sample
- sample_in  in  DW  decimated sample, valid with sample_valid
- ram_addr  out  AW  RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  DW  RAM write data, registered
- ram_rdata  in  DW  RAM read data, valid 1 cycle after ram_addr is presented
- audio_out  out  DW  playback sample, registered
- audio_valid  out  1  one-cycle pulse when audio_out updates
- stored_len  out  AW+1  number of valid samples in RAM, range 0..DEPTH
- busy  out  1  1 in REC or PLAY, or while the read pipeline drains
- led  out  4  progress thermometer

Behaviour:
- Reset (reset==0 at a clk edge) gives:
  - state IDLE; wr_ptr = rd_ptr = 0
  - ram_addr = 0, ram_we = 0, ram_wdata = 0
  - audio_out = IDLE_LEVEL, audio_valid = 0
  - stored_len = 0, busy = 0, led = 0000
  - read pipeline flushed
- Reset mid-operation aborts immediately. No further RAM write occurs, and no audio_valid comes from reads in flight.
- States: IDLE, REC, PLAY.
- Request priority each cycle: stop_req > rec_req > play_req.
  - rec_req or play_req outside IDLE is ignored.
  - rec_req and play_req in the same IDLE cycle: REC wins.
- IDLE -> REC on rec_req:
  - wr_ptr = 0, stored_len = 0 (the old recording is discarded).
- REC, on each sample_valid at cycle N:
  - Cycle N+1: ram_we = 1, ram_addr = wr_ptr, ram_wdata = sample_in as captured at N.
  - wr_ptr increments.
  - ram_we is 1 for exactly that one cycle.
- REC full: the write of address DEPTH-1 sets stored_len = DEPTH and returns to IDLE in the same cycle. wr_ptr wraps to 0.
- REC -> IDLE on stop_req: stored_len = number of writes already issued, including a write issued in the same cycle as stop_req.
  - A sample_valid coinciding with stop_req is dropped.
- IDLE -> PLAY on play_req, only if stored_len != 0; otherwise play_req is ignored. rd_ptr = 0.
- PLAY, on sample_valid at cycle N:
  - Cycle N+1: ram_addr = rd_ptr, ram_we = 0.
  - Cycle N+2: ram_rdata is valid.
  - Cycle N+3: audio_out = that data, audio_valid = 1.
  - Total latency from sample_valid to audio_valid is 3 cycles.
- PLAY end, when the read of rd_ptr == stored_len-1 is issued:
  - loop_en = 1: rd_ptr = 0 and PLAY continues.
  - loop_en = 0: go to IDLE; the in-flight read still completes and produces audio_valid.
- PLAY -> IDLE on stop_req: reads already issued still complete and produce audio_valid.
- busy = 1 in REC/PLAY. It stays 1 until the last pending audio_valid has fired; a new play_req/rec_req is accepted only when busy = 0.
- audio_out holds its last value between updates.
- RAM port ownership: only REC issues writes and only PLAY issues reads. ram_addr holds its last value otherwise.
- led, with p = the 2 MSBs of the active pointer:
  - REC: led[i] = 1 for i <= p(wr_ptr).
  - PLAY: led[i] = 1 for i >= p(rd_ptr).
  - IDLE: 0000.
- Arithmetic: all pointers are AW bits and wrap modulo DEPTH. stored_len is AW+1 bits so that DEPTH is representable.

Test Plan (DEPTH=16 for the bench):
- Reset values: hold reset=0 for 3 cycles -> every output at its reset value; audio_out = 8'h80, stored_len = 0.
- Full record: rec_req, then 20 strobes of 0x01..0x14 -> writes addr 0..15 with data 0x01..0x10, one cycle after each strobe. stored_len = 16, state IDLE, no writes from strobes 17..20.
- Partial record then playback: record 5 samples, stop_req, play_req, 6 strobes, loop_en = 0 -> stored_len = 5. audio_valid fires exactly 5 times, each 3 cycles after its strobe, with values matching the recording. busy drops after the 5th audio_valid.
- Looped playback: stored_len = 3 (data A,B,C), loop_en = 1, 7 strobes -> audio sequence A,B,C,A,B,C,A. stop_req then ends playback after in-flight reads complete.
- Collisions: rec_req + play_req in the same cycle -> REC. play_req during REC -> ignored. play_req with stored_len = 0 -> stays IDLE. stop_req coinciding with sample_valid in REC -> no write for that sample.
- Reset mid-playback: reset=0 one cycle after a read is issued -> no audio_valid afterwards, and all outputs return to their reset values.
